// File: rtl/spi_reg_bridge.sv
// Turns framed SPI slave bytes into register bus cycles: a command byte {RW, addr}
// followed by a data burst, with read data prefetched so read bursts never stall.
module spi_reg_bridge #(
   parameter int          ADDR_W   = 7,
   parameter logic [7:0]  STATUS   = 8'hA5,
   parameter bit          AUTO_INC = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_ss_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_rx_data,
   output logic [7:0]        s_tx_data,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE, CMD, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_DO
   } state_t;

   localparam logic [ADDR_W-1:0] INC = ADDR_W'(AUTO_INC);

   state_t     state;
   logic [7:0] prefetch;
   logic       ss_meta, ss_sync;
   logic       hs;

   // Chip select idles high, so the synchroniser resets to "deselected".
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_meta <= 1'b1;
         ss_sync <= 1'b1;
      end else begin
         ss_meta <= spi_ss_n;
         ss_sync <= ss_meta;
      end
   end

   always_comb begin
      s_ready = s_valid & (state == IDLE || state == CMD ||
                           state == RD_DATA || state == WR_DATA);
      case (state)
         CMD:     s_tx_data = STATUS;
         RD_DATA: s_tx_data = prefetch;
         default: s_tx_data = 8'h00;
      endcase
   end

   assign hs   = s_valid & s_ready;
   assign busy = (state != IDLE);

   // reg_addr is the burst address register itself; strobes are set on entry
   // to RD_REQ / WR_DO so they are high exactly while the FSM sits there.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         reg_addr  <= '0;
         prefetch  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (!ss_sync) state <= CMD;
            end
            CMD: begin
               if (ss_sync) begin
                  state <= IDLE;
               end else if (hs) begin
                  reg_addr <= s_rx_data[ADDR_W-1:0];
                  if (s_rx_data[7]) begin
                     state     <= RD_REQ;
                     reg_rd_en <= 1'b1;
                  end else begin
                     state <= WR_DATA;
                  end
               end
            end
            RD_REQ: begin
               state <= ss_sync ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
               prefetch <= reg_rdata;
               state    <= ss_sync ? IDLE : RD_DATA;
            end
            RD_DATA: begin
               if (ss_sync) begin
                  state <= IDLE;
               end else if (hs) begin
                  reg_addr  <= reg_addr + INC;
                  reg_rd_en <= 1'b1;
                  state     <= RD_REQ;
               end
            end
            WR_DATA: begin
               // An accepted write byte is always committed, even on abort.
               if (hs) begin
                  reg_wdata <= s_rx_data;
                  reg_wr_en <= 1'b1;
                  state     <= WR_DO;
               end else if (ss_sync) begin
                  state <= IDLE;
               end
            end
            WR_DO: begin
               reg_addr <= reg_addr + INC;
               state    <= ss_sync ? IDLE : WR_DATA;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: drives SPI slave bytes, models the register
// file, logs bus strobes and checks them against hand-computed values.
module tb_spi_reg_bridge;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_ss_n;
   logic       s_valid;
   logic [7:0] s_rx_data;
   logic       s_ready, s_ready0;
   logic [7:0] s_tx_data, s_tx_data0;
   logic       reg_wr_en, reg_rd_en, reg_wr_en0, reg_rd_en0;
   logic [6:0] reg_addr, reg_addr0;
   logic [7:0] reg_wdata, reg_wdata0;
   logic [7:0] reg_rdata;
   logic [7:0] reg_rdata0;
   logic       busy, busy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_reg_bridge #(.ADDR_W(7), .STATUS(8'hA5), .AUTO_INC(1'b1)) dut (
      .clk(clk), .rst(rst), .spi_ss_n(spi_ss_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_rx_data(s_rx_data), .s_tx_data(s_tx_data), .reg_wr_en(reg_wr_en),
      .reg_rd_en(reg_rd_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .busy(busy));

   spi_reg_bridge #(.ADDR_W(7), .STATUS(8'hA5), .AUTO_INC(1'b0)) dut0 (
      .clk(clk), .rst(rst), .spi_ss_n(spi_ss_n), .s_valid(s_valid), .s_ready(s_ready0),
      .s_rx_data(s_rx_data), .s_tx_data(s_tx_data0), .reg_wr_en(reg_wr_en0),
      .reg_rd_en(reg_rd_en0), .reg_addr(reg_addr0), .reg_wdata(reg_wdata0),
      .reg_rdata(reg_rdata0), .busy(busy0));

   // Register file: data only appears the cycle after a read strobe.
   logic [7:0] regs [128];
   always @(posedge clk) reg_rdata <= reg_rd_en ? regs[reg_addr] : 8'hEE;
   assign reg_rdata0 = 8'h00;

   // Strobe logs (cumulative; tests remember a base index)
   int         wr_cnt = 0, rd_cnt = 0, wr0_cnt = 0;
   logic [6:0] wr_a [64];
   logic [7:0] wr_d [64];
   logic [6:0] rd_a [64];
   logic [6:0] wr0_a [64];
   always @(posedge clk) begin
      if (reg_wr_en && wr_cnt < 64) begin
         wr_a[wr_cnt] <= reg_addr; wr_d[wr_cnt] <= reg_wdata; wr_cnt <= wr_cnt + 1;
      end
      if (reg_rd_en && rd_cnt < 64) begin
         rd_a[rd_cnt] <= reg_addr; rd_cnt <= rd_cnt + 1;
      end
      if (reg_wr_en0 && wr0_cnt < 64) begin
         wr0_a[wr0_cnt] <= reg_addr0; wr0_cnt <= wr0_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One slave byte: hold s_valid until accepted, return the tx byte loaded then.
   task automatic xfer(input logic [7:0] b, output logic [7:0] tx, input int gap);
      int n;
      @(negedge clk); s_valid = 1'b1; s_rx_data = b; #1;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      assert (s_ready === 1'b1) else begin
         errors++;
         $error("FAIL handshake observed=%b expected=1", s_ready);
      end
      tx = s_tx_data;
      @(posedge clk); #1;
      s_valid = 1'b0; s_rx_data = 8'h00;
      repeat (gap) @(posedge clk);
   endtask

   task automatic ss_low();
      @(negedge clk); spi_ss_n = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   task automatic ss_high();
      @(negedge clk); spi_ss_n = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] tx;
      int wb, rb, w0b;
      for (int i = 0; i < 128; i++) regs[i] = 8'(i);
      regs[3] = 8'hC1; regs[4] = 8'hC2; regs[5] = 8'hC3; regs[6] = 8'hC4;
      rst = 1'b1; spi_ss_n = 1'b1; s_valid = 1'b0; s_rx_data = 8'h00;
      repeat (3) @(posedge clk); #1;
      check("rst_tx", 32'(s_tx_data), 32'h00);
      check("rst_ready", 32'(s_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_wr", 32'(reg_wr_en), 32'h0);
      check("rst_rd", 32'(reg_rd_en), 32'h0);
      check("rst_addr", 32'(reg_addr), 32'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // 1: write burst 05,11,22,33
      wb = wr_cnt; rb = rd_cnt;
      ss_low();
      check("t1_busy", 32'(busy), 32'h1);
      xfer(8'h05, tx, 4); check("t1_miso1", 32'(tx), 32'hA5);
      xfer(8'h11, tx, 4); check("t1_miso2", 32'(tx), 32'h00);
      xfer(8'h22, tx, 4); check("t1_miso3", 32'(tx), 32'h00);
      xfer(8'h33, tx, 4);
      ss_high();
      check("t1_wr_cnt", 32'(wr_cnt - wb), 32'd3);
      check("t1_rd_cnt", 32'(rd_cnt - rb), 32'd0);
      check("t1_w0a", 32'(wr_a[wb]), 32'h05);   check("t1_w0d", 32'(wr_d[wb]), 32'h11);
      check("t1_w1a", 32'(wr_a[wb+1]), 32'h06); check("t1_w1d", 32'(wr_d[wb+1]), 32'h22);
      check("t1_w2a", 32'(wr_a[wb+2]), 32'h07); check("t1_w2d", 32'(wr_d[wb+2]), 32'h33);

      // 2: read burst from 3; the last handshake prefetches one extra (addr 6)
      wb = wr_cnt; rb = rd_cnt;
      ss_low();
      xfer(8'h83, tx, 4); check("t2_miso1", 32'(tx), 32'hA5);
      xfer(8'h00, tx, 4); check("t2_miso2", 32'(tx), 32'hC1);
      xfer(8'h00, tx, 4); check("t2_miso3", 32'(tx), 32'hC2);
      xfer(8'h00, tx, 4); check("t2_miso4", 32'(tx), 32'hC3);
      ss_high();
      check("t2_rd_cnt", 32'(rd_cnt - rb), 32'd4);
      check("t2_r0", 32'(rd_a[rb]), 32'h03);
      check("t2_r1", 32'(rd_a[rb+1]), 32'h04);
      check("t2_r2", 32'(rd_a[rb+2]), 32'h05);
      check("t2_r3", 32'(rd_a[rb+3]), 32'h06);
      check("t2_wr_cnt", 32'(wr_cnt - wb), 32'd0);

      // 3: address wrap, and fixed address with AUTO_INC=0
      wb = wr_cnt; w0b = wr0_cnt;
      ss_low();
      xfer(8'h7F, tx, 4);
      xfer(8'hAA, tx, 4);
      xfer(8'hBB, tx, 4);
      ss_high();
      check("t3_wr_cnt", 32'(wr_cnt - wb), 32'd2);
      check("t3_w0a", 32'(wr_a[wb]), 32'h7F);   check("t3_w0d", 32'(wr_d[wb]), 32'hAA);
      check("t3_w1a", 32'(wr_a[wb+1]), 32'h00); check("t3_w1d", 32'(wr_d[wb+1]), 32'hBB);
      check("t3_fix_cnt", 32'(wr0_cnt - w0b), 32'd2);
      check("t3_fix_a0", 32'(wr0_a[w0b]), 32'h7F);
      check("t3_fix_a1", 32'(wr0_a[w0b+1]), 32'h7F);

      // 4: abort after one write byte
      wb = wr_cnt; rb = rd_cnt;
      ss_low();
      xfer(8'h10, tx, 4);
      xfer(8'h44, tx, 4);
      check("t4_busy_pre", 32'(busy), 32'h1);
      @(negedge clk); spi_ss_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("t4_busy_post", 32'(busy), 32'h0);
      repeat (10) @(posedge clk);
      check("t4_wr_cnt", 32'(wr_cnt - wb), 32'd1);
      check("t4_wa", 32'(wr_a[wb]), 32'h10);
      check("t4_wd", 32'(wr_d[wb]), 32'h44);
      check("t4_rd_cnt", 32'(rd_cnt - rb), 32'd0);

      // 5: stray byte while deselected
      wb = wr_cnt; rb = rd_cnt;
      xfer(8'h99, tx, 4);
      check("t5_tx", 32'(tx), 32'h00);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_wr_cnt", 32'(wr_cnt - wb), 32'd0);
      check("t5_rd_cnt", 32'(rd_cnt - rb), 32'd0);

      // 6: reset during RD_WAIT, then a normal frame
      ss_low();
      xfer(8'h83, tx, 0);
      check("t6_rdreq", 32'(reg_rd_en), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_rd", 32'(reg_rd_en), 32'h0);
      check("t6_wr", 32'(reg_wr_en), 32'h0);
      check("t6_addr", 32'(reg_addr), 32'h0);
      check("t6_wdata", 32'(reg_wdata), 32'h0);
      check("t6_tx", 32'(s_tx_data), 32'h0);
      rst = 1'b0;
      ss_high();
      wb = wr_cnt;
      ss_low();
      xfer(8'h02, tx, 4); check("t6_miso1", 32'(tx), 32'hA5);
      xfer(8'h5A, tx, 4);
      ss_high();
      check("t6_wr_cnt", 32'(wr_cnt - wb), 32'd1);
      check("t6_wa", 32'(wr_a[wb]), 32'h02);
      check("t6_wd", 32'(wr_d[wb]), 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
